// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract controller.
package serial_add_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/OVERFLOW_ADD.sv
// Signed-overflow check for an addition, from the operand and result sign bits.
module OVERFLOW_ADD (
  input  logic sign_a,
  input  logic sign_b,
  input  logic sign_s,
  output logic ovf
);

  assign ovf = (sign_a == sign_b) && (sign_s != sign_a);

endmodule

// File: rtl/fa_slice.sv
// One-bit full adder; the only arithmetic in the serial datapath.
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial two's-complement add/subtract: one full-adder slice stepped
// LSB first over WIDTH cycles, with start/ready/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNTW = $clog2(WIDTH);
  localparam int unsigned SW   = WIDTH - 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sh_a_q, sh_a_d;
  logic [WIDTH-1:0]  sh_b_q, sh_b_d;
  logic [SW-1:0]     sh_s_q, sh_s_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              s_c, co_c, ovf_c, ready_c;

  fa_slice u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .s    (s_c),
    .cout (co_c)
  );

  OVERFLOW_ADD u_ovf (
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .sign_s (s_c),
    .ovf    (ovf_c)
  );

  // Handshake flags decode straight from the state register.
  assign ready_c = (state_q == IDLE) || (state_q == DONE);
  assign ready   = ready_c;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sh_s_d   = sh_s_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    // Subtraction is a + ~b + 1: invert b and seed the carry with sub.
    if (start && ready_c) begin
      state_d  = RUN;
      sh_a_d   = a;
      sh_b_d   = b ^ {WIDTH{sub}};
      carry_d  = sub;
      cnt_d    = '0;
      sign_a_d = a[WIDTH-1];
      sign_b_d = b[WIDTH-1] ^ sub;
    end else begin
      case (state_q)
        RUN: begin
          carry_d = co_c;
          sh_a_d  = sh_a_q >> 1;
          sh_b_d  = sh_b_q >> 1;
          sh_s_d  = SW'({s_c, sh_s_q} >> 1);
          cnt_d   = CNTW'(cnt_q + 1'b1);
          if (cnt_q == CNTW'(WIDTH - 1)) begin
            sum_d   = {s_c, sh_s_q};
            cout_d  = co_c;
            ovf_d   = ovf_c;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_s_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_s_q   <= sh_s_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_vec  = 0;
  int n_miss = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts edges from the accept edge (edge 1) until done is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic [7:0] es, input logic ec,
                        input logic eo);
    int edges;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~ia; b = 8'h5A; sub = ~isub;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(edges);
    check({tag, "_lat"}, 32'(edges), 32'd9);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int edges;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    run_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    check("done_1cyc", 32'(done), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("sub0503", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);

    // start pulsed mid-RUN with other operands must be ignored
    @(negedge clk);
    a = 8'h7F; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; sub = 1'b1; start = 1'b1;
    check("ign_ready", 32'(ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    edges = 4;
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("ign_lat", 32'(edges), 32'd9);
    check("ign_sum", 32'(sum), 32'h80);
    check("ign_ovf", 32'(ovf), 32'd1);

    // back-to-back: start held in DONE cycle
    @(negedge clk);
    a = 8'h05; b = 8'h03; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    check("b2b1_sum", 32'(sum), 32'h02);
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'hEE; b = 8'hEE;
    check("b2b2_busy", 32'(busy), 32'd1);
    check("b2b2_done", 32'(done), 32'd0);
    check("b2b2_hold", 32'(sum), 32'h02);
    wait_done(edges);
    check("b2b2_lat", 32'(edges), 32'd9);
    check("b2b2_sum", 32'(sum), 32'h30);
    check("b2b2_cout", 32'(cout), 32'd0);

    // reset asserted mid-RUN at cnt=4, after a result with ovf set
    run_op("pre_rst", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'hFF; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_sum", 32'(sum), 32'h00);
    check("mrst_ovf", 32'(ovf), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(ready), 32'd1);
    edges = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) edges++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) edges++;
    end
    check("mrst_nodone", 32'(edges), 32'd0);
    check("mrst_idle", 32'(ready), 32'd1);
    run_op("post_rst", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
